// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter request manager.
package arb_pkg;

  localparam int unsigned ArbNDefault    = 16;
  localparam int unsigned ArbIdxWDefault = 4;

  // IDLE: no grant held; HOLD: a captured index is presented on out_idx.
  typedef enum logic [0:0] {
    StIdle,
    StHold
  } arb_state_e;

  // True when more than one bit of a (zero-extended) grant vector is set.
  function automatic logic multi_hot(input logic [15:0] vec);
    return (vec & (vec - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/LeftArbiter16bits.sv
// Highest-index-wins combinational arbiter: one-hot grant for the top request bit.
module LeftArbiter16bits (
  input  logic [15:0] req,
  output logic [15:0] gnt
);

  // Last match in an ascending scan is the highest requester.
  always_comb begin
    gnt = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (req[k]) gnt = 16'd1 << k;
    end
  end

endmodule

// File: rtl/arb_grant_encoder.sv
// Highest-set-bit encoder: binary index of the top set bit plus a nonzero flag.
module arb_grant_encoder #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             nz_o
);

  // Scan upwards so the highest set bit is the last to write idx_o.
  always_comb begin
    idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (vec_i[k]) idx_o = IDX_W'(k);
    end
    nz_o = |vec_i;
  end

endmodule

// File: rtl/arb_request_manager.sv
// Pending-request register in front of an external left arbiter; captures and
// presents one grant index per cycle with valid/ready backpressure.
// Optional sticky grant-protocol checker enabled by defining ARB_ONEHOT_CHECK_EN.
module arb_request_manager
  import arb_pkg::*;
#(
  parameter int unsigned N     = ArbNDefault,
  parameter int unsigned IDX_W = ArbIdxWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_set,
  output logic [N-1:0]     arb_r,
  input  logic [N-1:0]     arb_g,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             busy
`ifdef ARB_ONEHOT_CHECK_EN
  ,
  output logic             err
`endif
);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_nz;
  logic             capture;
  logic [N-1:0]     clear;

  arb_grant_encoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i (arb_g),
    .idx_o (gnt_idx),
    .nz_o  (gnt_nz)
  );

  // Next-state: capture when a grant is offered and no index is held or it is taken.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    capture     = gnt_nz && ((state_q == StIdle) || out_ready);
    clear       = '0;
    if (capture) begin
      clear[gnt_idx] = 1'b1;
      state_d        = StHold;
      out_valid_d    = 1'b1;
      out_idx_d      = gnt_idx;
    end else if ((state_q == StHold) && out_ready) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end
    // Set wins over clear on the same bit.
    pending_d = (pending_q & ~clear) | req_set;
  end

  // FSM, pending register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign arb_r     = pending_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign busy      = (|pending_q) | out_valid_q;

`ifdef ARB_ONEHOT_CHECK_EN
  logic err_q, err_d;

  // Sticky flag: multi-hot grant or a grant for a bit not currently requested.
  always_comb begin
    err_d = err_q;
    if (gnt_nz && (multi_hot(16'(arb_g)) || (|(arb_g & ~pending_q)))) err_d = 1'b1;
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_arb_request_manager.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the pending set and the presented grant.
module tb_arb_request_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_set;
  logic [15:0] arb_r;
  logic [15:0] arb_g;
  logic [15:0] arb_gnt_lft;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        out_ready;
  logic        busy;
  logic        force_en;
  logic [15:0] force_val;
`ifdef ARB_ONEHOT_CHECK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [15:0] m_pend;
  logic        m_valid;
  int          m_idx;
  logic        m_err;

  always #5 clk = ~clk;

  LeftArbiter16bits u_arb (
    .req (arb_r),
    .gnt (arb_gnt_lft)
  );

  assign arb_g = force_en ? force_val : arb_gnt_lft;

  arb_request_manager #(
    .N     (16),
    .IDX_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_set   (req_set),
    .arb_r     (arb_r),
    .arb_g     (arb_g),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef ARB_ONEHOT_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int top_bit(input logic [15:0] v);
    for (int k = 15; k >= 0; k--) if (v[k]) return k;
    return -1;
  endfunction

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input logic [15:0] req, input logic rdy);
    logic [15:0] g;
    int          t;
    req_set   = req;
    out_ready = rdy;
    g = force_en ? force_val : (m_pend == 16'd0 ? 16'd0 : (16'd1 << top_bit(m_pend)));
    if (rst) begin
      m_pend = '0; m_valid = 1'b0; m_idx = 0; m_err = 1'b0;
    end else begin
      if (g != 16'd0 && (($countones(g) > 1) || ((g & ~m_pend) != 16'd0))) m_err = 1'b1;
      if (g != 16'd0 && (!m_valid || rdy)) begin
        t       = top_bit(g);
        m_pend  = m_pend & ~(16'd1 << t);
        m_valid = 1'b1;
        m_idx   = t;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      m_pend = m_pend | req;
    end
    @(posedge clk);
    #1;
    check_eq("arb_r", 32'(arb_r), 32'(m_pend));
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_idx", 32'(out_idx), 32'(m_idx));
    check_eq("busy", 32'(busy), 32'((m_pend != 16'd0) || m_valid));
`ifdef ARB_ONEHOT_CHECK_EN
    check_eq("err", 32'(err), 32'(m_err));
`endif
  endtask

  initial begin
    rst = 1'b1; req_set = '0; out_ready = 1'b0; force_en = 1'b0; force_val = '0;
    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_err = 1'b0;
    step(16'h0, 1'b0);
    step(16'hFFFF, 1'b1);
    check_eq("rst_pend", 32'(arb_r), 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;

    // Single request.
    step(16'h0010, 1'b1);
    check_eq("s1_valid_early", 32'(out_valid), 32'h0);
    step(16'h0000, 1'b1);
    check_eq("s1_valid", 32'(out_valid), 32'h1);
    check_eq("s1_idx", 32'(out_idx), 32'd4);
    step(16'h0000, 1'b1);
    check_eq("s1_drop", 32'(out_valid), 32'h0);
    check_eq("s1_busy", 32'(busy), 32'h0);

    // Priority drain, one grant per cycle.
    step(16'h8421, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(16'h0000, 1'b1);
      check_eq("drain_valid", 32'(out_valid), 32'h1);
      check_eq("drain_idx", 32'(out_idx), 32'(15 - 5 * i));
    end
    step(16'h0000, 1'b1);
    check_eq("drain_end", 32'(out_valid), 32'h0);

    // Backpressure.
    step(16'h0006, 1'b0);
    step(16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(16'h0000, 1'b0);
      check_eq("bp_idx", 32'(out_idx), 32'd2);
      check_eq("bp_pend", 32'(arb_r), 32'h0002);
    end
    step(16'h0000, 1'b1);
    check_eq("bp_next", 32'(out_idx), 32'd1);
    step(16'h0000, 1'b1);

    // Set/clear collision on bit 7.
    step(16'h0080, 1'b1);
    step(16'h0080, 1'b1);
    check_eq("coll_idx", 32'(out_idx), 32'd7);
    check_eq("coll_pend", 32'(arb_r), 32'h0080);
    step(16'h0000, 1'b1);
    check_eq("coll_again", 32'(out_idx), 32'd7);
    check_eq("coll_again_v", 32'(out_valid), 32'h1);
    step(16'h0000, 1'b1);

    // Reset mid-operation.
    step(16'hFFFF, 1'b0);
    step(16'h0000, 1'b0);
    check_eq("mid_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    step(16'h1234, 1'b0);
    rst = 1'b0;
    check_eq("mid_rst_pend", 32'(arb_r), 32'h0);
    check_eq("mid_rst_idx", 32'(out_idx), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
`ifdef ARB_ONEHOT_CHECK_EN
    force_en = 1'b1; force_val = 16'h0003;
    step(16'h0000, 1'b1);
    force_en = 1'b0;
    check_eq("err_set", 32'(err), 32'h1);
    step(16'h0000, 1'b1);
    step(16'h0000, 1'b1);
    check_eq("err_sticky", 32'(err), 32'h1);
    rst = 1'b1;
    step(16'h0000, 1'b1);
    rst = 1'b0;
    check_eq("err_clr", 32'(err), 32'h0);
`endif

    // Randomized traffic, occasional forced grants and resets.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r;
      logic        rdy;
      r   = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0;
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      force_en = ($urandom_range(0, 15) == 0);
      force_val = ($urandom_range(0, 1) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'($urandom);
      step(r, rdy);
    end
    rst = 1'b0;
    force_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
